// File: rtl/pixel_frame_assembler_pkg.sv
// Shared pixel types: default frame geometry, FILL/FULL state encoding, popcount helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_pkg;

  localparam int ROW_SIZE_DEF = 280;  // 28 pixels x 10 bits
  localparam int NUM_ROWS_DEF = 28;
  localparam int SEL_BIT_DEF  = 5;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Number of set bits in a mask of up to 64 rows.
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pixel_frame_assembler_if.sv
// Row-in / frame-out bundle between a row producer and the frame assembler (PIXEL_ROW_ADDR_EN adds in_addr).
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready per row; frame_valid held until frame_ack.
interface pixel_frame_assembler_if
  import pixel_pkg::*;
#(
  parameter int ROW_SIZE = ROW_SIZE_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int SEL_BIT  = SEL_BIT_DEF
);

  logic                         in_valid;
  logic                         in_ready;
  logic [ROW_SIZE-1:0]          in_row;
`ifdef PIXEL_ROW_ADDR_EN
  logic [SEL_BIT-1:0]           in_addr;
`endif
  logic [ROW_SIZE*NUM_ROWS-1:0] frame_out;
  logic                         frame_valid;
  logic                         frame_ack;
  logic [SEL_BIT-1:0]           row_count;

  // Producer/consumer side.
  modport master (
`ifdef PIXEL_ROW_ADDR_EN
    output in_addr,
`endif
    output in_valid,
    output in_row,
    output frame_ack,
    input  in_ready,
    input  frame_out,
    input  frame_valid,
    input  row_count
  );

  // Assembler side.
  modport slave (
`ifdef PIXEL_ROW_ADDR_EN
    input  in_addr,
`endif
    input  in_valid,
    input  in_row,
    input  frame_ack,
    output in_ready,
    output frame_out,
    output frame_valid,
    output row_count
  );

endinterface

// File: rtl/pixel_frame_assembler_row_reg.sv
// One pixel row of storage: load on write enable, hold otherwise.
// Latency: 1 cycle from we to q.
// Backpressure: none; always writable.
module pixel_row_reg #(
  parameter int ROW_SIZE = 280
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ROW_SIZE-1:0] d,
  output logic [ROW_SIZE-1:0] q
);

  logic [ROW_SIZE-1:0] row_q, row_d;

  // Next row value: new data on write, otherwise hold.
  always_comb begin
    row_d = row_q;
    if (we) row_d = d;
  end

  // Row storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
  end

  assign q = row_q;

endmodule

// File: rtl/pixel_frame_assembler.sv
// Collects NUM_ROWS pixel rows into one flat frame (PIXEL_ROW_ADDR_EN: rows written at in_addr, tracked by a mask).
// Latency: row visible on frame_out 1 cycle after acceptance; frame_valid 1 cycle after the completing row.
// Backpressure: in_ready is registered (no in_valid->in_ready path); low while a full frame waits for frame_ack.
module pixel_frame_assembler
  import pixel_pkg::*;
#(
  parameter int ROW_SIZE = ROW_SIZE_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int SEL_BIT  = SEL_BIT_DEF
) (
  input logic clk,
  input logic rst_n,
  pixel_frame_assembler_if.slave bus
);

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               frame_valid_q, frame_valid_d;
  logic [SEL_BIT-1:0] row_count_q, row_count_d;
  logic [SEL_BIT-1:0] wr_sel;
  logic               accept;
  logic [NUM_ROWS-1:0]          row_we;
  logic [ROW_SIZE*NUM_ROWS-1:0] frame_flat;

`ifdef PIXEL_ROW_ADDR_EN
  // Which rows of the current frame have been written at least once.
  logic [NUM_ROWS-1:0] mask_q, mask_d;
  assign wr_sel = bus.in_addr;
`else
  logic [SEL_BIT-1:0] wr_ptr_q, wr_ptr_d;
  assign wr_sel = wr_ptr_q;
`endif

  // in_ready_q is a flop, so the handshake never loops back combinationally.
  assign accept = bus.in_valid & in_ready_q;

  // Next-state logic for the FILL/FULL controller and its row bookkeeping.
  always_comb begin
    state_d     = state_q;
    row_count_d = row_count_q;
`ifdef PIXEL_ROW_ADDR_EN
    mask_d      = mask_q;
`else
    wr_ptr_d    = wr_ptr_q;
`endif
    case (state_q)
      FILL: begin
        if (accept) begin
`ifdef PIXEL_ROW_ADDR_EN
          // Out-of-range addresses complete the handshake but mark nothing.
          if (32'(wr_sel) < NUM_ROWS) begin
            mask_d = mask_q | (NUM_ROWS'(1) << wr_sel);
          end
          row_count_d = SEL_BIT'(popcount64(64'(mask_d)));
          if (&mask_d) state_d = FULL;
`else
          wr_ptr_d    = wr_ptr_q + 1'b1;
          row_count_d = row_count_q + 1'b1;
          if (32'(wr_ptr_q) == NUM_ROWS - 1) state_d = FULL;
`endif
        end
      end
      FULL: begin
        // Row contents are kept; only the fill bookkeeping restarts.
        if (bus.frame_ack) begin
          state_d     = FILL;
          row_count_d = '0;
`ifdef PIXEL_ROW_ADDR_EN
          mask_d      = '0;
`else
          wr_ptr_d    = '0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
    in_ready_d    = (state_d == FILL);
    frame_valid_d = (state_d == FULL);
  end

  // Controller state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      row_count_q   <= '0;
`ifdef PIXEL_ROW_ADDR_EN
      mask_q        <= '0;
`else
      wr_ptr_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      row_count_q   <= row_count_d;
`ifdef PIXEL_ROW_ADDR_EN
      mask_q        <= mask_d;
`else
      wr_ptr_q      <= wr_ptr_d;
`endif
    end
  end

  // One register per row; row k sits at the LSB end for k = 0.
  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row
    assign row_we[k] = accept && (32'(wr_sel) == k);

    pixel_row_reg #(
      .ROW_SIZE(ROW_SIZE)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (row_we[k]),
      .d    (bus.in_row),
      .q    (frame_flat[ROW_SIZE*k +: ROW_SIZE])
    );
  end

  assign bus.frame_out   = frame_flat;
  assign bus.in_ready    = in_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.row_count   = row_count_q;

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Directed bench for pixel_frame_assembler with a row scoreboard and frame model.
// Latency: checks sampled 1 time unit after the active clock edge.
// Backpressure: exercises in_ready low in FULL, ack release, ack ignored in FILL.
module tb_pixel_frame_assembler;
  import pixel_pkg::*;

  localparam int RS = ROW_SIZE_DEF;
  localparam int NR = NUM_ROWS_DEF;

  typedef struct {
    int            slot;
    logic [RS-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  exp_t          sb[$];
  logic [RS-1:0] model[NR];

  pixel_frame_assembler_if bus ();

  pixel_frame_assembler dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply every queued accepted row to the frame model (out-of-range slots drop).
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.slot >= 0 && e.slot < NR) model[e.slot] = e.data;
    end
  endtask

  task automatic chk_frame(input string tag);
    drain();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s_slice%0d", tag, k), bus.frame_out[RS*k +: RS], model[k]);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endtask

  // Offer one row for one cycle; the caller knows the block is in FILL.
  task automatic put_row(input logic [RS-1:0] row, input int slot);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_row   = row;
`ifdef PIXEL_ROW_ADDR_EN
    bus.in_addr  = 5'(slot);
`endif
    e.slot = slot;
    e.data = row;
    sb.push_back(e);
    tick();
  endtask

  function automatic logic [RS-1:0] pat(input int v);
    logic [9:0] p;
    p = 10'(v);
    return {28{p}};
  endfunction

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1;
    clear_model();
    chk("rst_in_ready", RS'(bus.in_ready), '0);
    chk("rst_frame_valid", RS'(bus.frame_valid), '0);
    chk("rst_row_count", RS'(bus.row_count), '0);
    chk_frame("rst_frame");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_release_in_ready", RS'(bus.in_ready), RS'(1));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.frame_ack = 1'b0;
`ifdef PIXEL_ROW_ADDR_EN
    bus.in_addr   = '0;
`endif
    clear_model();

    // Reset state before any clock edge.
    #3;
    chk("por_in_ready", RS'(bus.in_ready), '0);
    chk("por_frame_valid", RS'(bus.frame_valid), '0);
    chk("por_row_count", RS'(bus.row_count), '0);
    chk_frame("por_frame");
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("pre_edge_in_ready", RS'(bus.in_ready), '0);
    tick();
    chk("first_edge_in_ready", RS'(bus.in_ready), RS'(1));

    // 28 consecutive rows, row k = {28{k}}.
    for (int k = 0; k < NR; k++) begin
      put_row(pat(k), k);
      if (k == NR - 2) begin
        chk("fill27_frame_valid", RS'(bus.frame_valid), '0);
        chk("fill27_row_count", RS'(bus.row_count), RS'(NR - 1));
      end
    end
    chk("full_frame_valid", RS'(bus.frame_valid), RS'(1));
    chk("full_in_ready", RS'(bus.in_ready), '0);
    chk("full_row_count", RS'(bus.row_count), RS'(NR));
    chk_frame("full");

    // Rows offered while FULL are not accepted.
    bus.in_valid = 1'b1;
    bus.in_row   = {RS{1'b1}};
    repeat (5) tick();
    bus.in_valid = 1'b0;
    chk("hold_frame_valid", RS'(bus.frame_valid), RS'(1));
    chk("hold_row_count", RS'(bus.row_count), RS'(NR));
    chk_frame("hold");

    // Ack, then a row on the very next cycle.
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("ack_in_ready", RS'(bus.in_ready), RS'(1));
    chk("ack_frame_valid", RS'(bus.frame_valid), '0);
    chk("ack_row_count", RS'(bus.row_count), '0);
    put_row(pat(10'h155), 0);
    bus.in_valid = 1'b0;
    chk("after_ack_row_count", RS'(bus.row_count), RS'(1));
    chk_frame("after_ack");

    // Ack during FILL at row_count=5 is ignored.
    for (int k = 1; k < 5; k++) put_row(pat(100 + k), k);
    bus.in_valid  = 1'b0;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("fill_ack_row_count", RS'(bus.row_count), RS'(5));
    chk("fill_ack_in_ready", RS'(bus.in_ready), RS'(1));
    chk("fill_ack_frame_valid", RS'(bus.frame_valid), '0);

    // Reset mid-fill after 10 rows, then the next row lands in slice 0.
    for (int k = 5; k < 10; k++) put_row(pat(200 + k), k);
    bus.in_valid = 1'b0;
    chk("ten_row_count", RS'(bus.row_count), RS'(10));
    pulse_reset();
    put_row(pat(10'h2AB), 0);
    bus.in_valid = 1'b0;
    chk("post_rst_row_count", RS'(bus.row_count), RS'(1));
    chk_frame("post_rst");

`ifdef PIXEL_ROW_ADDR_EN
    // Addressed writes: duplicate, out-of-range, then the rest in reverse.
    pulse_reset();
    put_row(pat(10'h0A1), 3);
    chk("addr3a_row_count", RS'(bus.row_count), RS'(1));
    put_row(pat(10'h0B2), 3);
    chk("addr3b_row_count", RS'(bus.row_count), RS'(1));
    put_row(pat(10'h0C3), 30);
    chk("addr30_row_count", RS'(bus.row_count), RS'(1));
    begin
      int n;
      n = 1;
      for (int a = NR - 1; a >= 0; a--) begin
        if (a != 3) begin
          put_row(pat(300 + a), a);
          n++;
          if (a != 0) chk($sformatf("addr%0d_row_count", a), RS'(bus.row_count), RS'(n));
        end
      end
    end
    bus.in_valid = 1'b0;
    chk("addr_full_frame_valid", RS'(bus.frame_valid), RS'(1));
    chk("addr_full_row_count", RS'(bus.row_count), RS'(NR));
    chk_frame("addr_full");
    chk("addr_slice3_second", bus.frame_out[RS*3 +: RS], pat(10'h0B2));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
